lector_memoria_rtc: RTL and testbench

- Read-side client of the RTC register memory (16 x 8 bit registers, registered read port with address ADD2 and data Dato2).
- Sweeps register addresses 0..NUM_REGS-1 and captures each byte into a shadow bank.
- Publishes a coherent snapshot of time, date and chronometer fields to the display/VGA logic.
- Flags when the chronometer reaches zero.

---
 rtl/lector_memoria_rtc.sv | 211 +++++++++++++++++++++
 tb/tb_lector_memoria_rtc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lector_memoria_rtc.sv
// rtl/lector_memoria_rtc.sv - RTC register memory reader publishing coherent time/date/chronometer snapshots
module lector_memoria_rtc #(
   parameter int NUM_REGS    = 12,
   parameter int AUTO_PERIOD = 0,
   parameter int CNT_W       = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [3:0] ADD2,
   input  logic [7:0] Dato2,
   output logic [7:0] seg,
   output logic [7:0] min,
   output logic [7:0] hor,
   output logic [7:0] dia,
   output logic [7:0] mes,
   output logic [7:0] anio,
   output logic [7:0] crono_hor,
   output logic [7:0] crono_min,
   output logic [7:0] crono_seg,
   output logic       crono_activo,
   output logic       fin_crono,
   output logic       listo,
   output logic       ocupado
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0]       LAST_ADDR = 4'(NUM_REGS - 1);
   localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_PERIOD - 1);
   localparam logic [7:0]       CRONO_ON  = 8'hFF;

   state_t           state_q, state_d;
   logic [3:0]       add_q, add_d;
   logic [3:0]       idx_p_q, idx_p_d;
   logic             v_p_q, v_p_d;
   logic             ocupado_q, ocupado_d;
   logic             listo_q, listo_d;
   logic             fin_q, fin_d;
   logic             activo_q, activo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [7:0] seg_q, seg_d;
   logic [7:0] min_q, min_d;
   logic [7:0] hor_q, hor_d;
   logic [7:0] dia_q, dia_d;
   logic [7:0] mes_q, mes_d;
   logic [7:0] anio_q, anio_d;
   logic [7:0] chor_q, chor_d;
   logic [7:0] cmin_q, cmin_d;
   logic [7:0] cseg_q, cseg_d;

   // Shadow bank: holds the bytes of the sweep in progress, never visible directly
   logic [7:0] shadow_q [16];

   logic auto_hit;
   logic trig;

   assign auto_hit = (AUTO_PERIOD != 0) && (cnt_q == AUTO_LAST);
   assign trig     = start | auto_hit;

   // Free-running auto-sweep counter, wraps at AUTO_PERIOD-1 and stays idle at 0 when disabled
   always_comb begin
      cnt_d = cnt_q;
      if (AUTO_PERIOD == 0) begin
         cnt_d = '0;
      end else if (cnt_q == AUTO_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Sweep sequencer: next state, address issue, capture pipeline and atomic snapshot load
   always_comb begin
      state_d   = state_q;
      add_d     = add_q;
      idx_p_d   = idx_p_q;
      v_p_d     = 1'b0;
      ocupado_d = ocupado_q;
      listo_d   = 1'b0;
      fin_d     = 1'b0;
      activo_d  = activo_q;
      seg_d     = seg_q;
      min_d     = min_q;
      hor_d     = hor_q;
      dia_d     = dia_q;
      mes_d     = mes_q;
      anio_d    = anio_q;
      chor_d    = chor_q;
      cmin_d    = cmin_q;
      cseg_d    = cseg_q;
      case (state_q)
         IDLE: begin
            if (trig) begin
               add_d     = 4'd0;
               ocupado_d = 1'b1;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            // the address on ADD2 this cycle returns its byte next cycle
            v_p_d   = 1'b1;
            idx_p_d = add_q;
            if (add_q == LAST_ADDR) begin
               state_d = DRAIN;
            end else begin
               add_d = add_q + 4'd1;
            end
         end
         DRAIN: begin
            // the last byte lands in the shadow bank on this edge
            state_d = DONE;
         end
         DONE: begin
            seg_d     = shadow_q[0];
            min_d     = shadow_q[1];
            hor_d     = shadow_q[2];
            dia_d     = shadow_q[3];
            mes_d     = shadow_q[4];
            anio_d    = shadow_q[5];
            chor_d    = shadow_q[7];
            cmin_d    = shadow_q[8];
            cseg_d    = shadow_q[9];
            activo_d  = (shadow_q[11] == CRONO_ON);
            fin_d     = activo_q && (shadow_q[11] != CRONO_ON);
            listo_d   = 1'b1;
            ocupado_d = 1'b0;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, pipeline and published snapshot registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         add_q     <= 4'd0;
         idx_p_q   <= 4'd0;
         v_p_q     <= 1'b0;
         ocupado_q <= 1'b0;
         listo_q   <= 1'b0;
         fin_q     <= 1'b0;
         activo_q  <= 1'b0;
         cnt_q     <= '0;
         seg_q     <= 8'd0;
         min_q     <= 8'd0;
         hor_q     <= 8'd0;
         dia_q     <= 8'd0;
         mes_q     <= 8'd0;
         anio_q    <= 8'd0;
         chor_q    <= 8'd0;
         cmin_q    <= 8'd0;
         cseg_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         add_q     <= add_d;
         idx_p_q   <= idx_p_d;
         v_p_q     <= v_p_d;
         ocupado_q <= ocupado_d;
         listo_q   <= listo_d;
         fin_q     <= fin_d;
         activo_q  <= activo_d;
         cnt_q     <= cnt_d;
         seg_q     <= seg_d;
         min_q     <= min_d;
         hor_q     <= hor_d;
         dia_q     <= dia_d;
         mes_q     <= mes_d;
         anio_q    <= anio_d;
         chor_q    <= chor_d;
         cmin_q    <= cmin_d;
         cseg_q    <= cseg_d;
      end
   end

   // Capture the memory byte for the index issued one cycle earlier
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            shadow_q[i] <= 8'd0;
         end
      end else if (v_p_q) begin
         shadow_q[idx_p_q] <= Dato2;
      end
   end

   assign ADD2         = add_q;
   assign seg          = seg_q;
   assign min          = min_q;
   assign hor          = hor_q;
   assign dia          = dia_q;
   assign mes          = mes_q;
   assign anio         = anio_q;
   assign crono_hor    = chor_q;
   assign crono_min    = cmin_q;
   assign crono_seg    = cseg_q;
   assign crono_activo = activo_q;
   assign fin_crono    = fin_q;
   assign listo        = listo_q;
   assign ocupado      = ocupado_q;

endmodule

// File: tb/tb_lector_memoria_rtc.sv
// tb/tb_lector_memoria_rtc.sv - scoreboard bench for lector_memoria_rtc
module tb_lector_memoria_rtc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, reset_a, start;
   logic [7:0] mem [16];

   logic [3:0] add2;
   logic [7:0] dato2;
   logic [7:0] seg, min, hor, dia, mes, anio, crono_hor, crono_min, crono_seg;
   logic       crono_activo, fin_crono, listo, ocupado;

   logic [3:0] add_a10, add_a40;
   logic [7:0] dato_a10, dato_a40;
   logic [7:0] a10_o [9];
   logic [7:0] a40_o [9];
   logic       act_a10, fin_a10, listo_a10, ocup_a10;
   logic       act_a40, fin_a40, listo_a40, ocup_a40;

   lector_memoria_rtc #(.NUM_REGS(12), .AUTO_PERIOD(0), .CNT_W(24)) dut (
      .clk(clk), .reset(reset), .start(start), .ADD2(add2), .Dato2(dato2),
      .seg(seg), .min(min), .hor(hor), .dia(dia), .mes(mes), .anio(anio),
      .crono_hor(crono_hor), .crono_min(crono_min), .crono_seg(crono_seg),
      .crono_activo(crono_activo), .fin_crono(fin_crono), .listo(listo), .ocupado(ocupado)
   );

   lector_memoria_rtc #(.NUM_REGS(12), .AUTO_PERIOD(10), .CNT_W(8)) dut_a10 (
      .clk(clk), .reset(reset_a), .start(1'b0), .ADD2(add_a10), .Dato2(dato_a10),
      .seg(a10_o[0]), .min(a10_o[1]), .hor(a10_o[2]), .dia(a10_o[3]), .mes(a10_o[4]), .anio(a10_o[5]),
      .crono_hor(a10_o[6]), .crono_min(a10_o[7]), .crono_seg(a10_o[8]),
      .crono_activo(act_a10), .fin_crono(fin_a10), .listo(listo_a10), .ocupado(ocup_a10)
   );

   lector_memoria_rtc #(.NUM_REGS(12), .AUTO_PERIOD(40), .CNT_W(8)) dut_a40 (
      .clk(clk), .reset(reset_a), .start(1'b0), .ADD2(add_a40), .Dato2(dato_a40),
      .seg(a40_o[0]), .min(a40_o[1]), .hor(a40_o[2]), .dia(a40_o[3]), .mes(a40_o[4]), .anio(a40_o[5]),
      .crono_hor(a40_o[6]), .crono_min(a40_o[7]), .crono_seg(a40_o[8]),
      .crono_activo(act_a40), .fin_crono(fin_a40), .listo(listo_a40), .ocupado(ocup_a40)
   );

   // registered-read memory model, one per reader
   always @(posedge clk) begin
      dato2    <= mem[add2];
      dato_a10 <= mem[add_a10];
      dato_a40 <= mem[add_a40];
   end

   typedef struct packed {
      logic [71:0] f;
      logic        act;
      logic        fin;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   bad_change = 0;

   task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] req);
      n_total++;
      if (got === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h", nm, got, req);
   endtask

   function automatic exp_t mk(input int s, input int mi, input int h, input int d, input int me,
                               input int a, input int ch, input int cm, input int cs,
                               input logic act, input logic fin);
      exp_t e;
      e.f   = {8'(s), 8'(mi), 8'(h), 8'(d), 8'(me), 8'(a), 8'(ch), 8'(cm), 8'(cs)};
      e.act = act;
      e.fin = fin;
      return e;
   endfunction

   // scoreboard monitor: every listo pops one expected snapshot
   logic [71:0] got_f;
   logic [72:0] cur, prev = '0;
   exp_t        e_pop;
   always @(negedge clk) begin
      got_f = {seg, min, hor, dia, mes, anio, crono_hor, crono_min, crono_seg};
      cur   = {got_f, crono_activo};
      if (listo) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_listo: got listo=1 required no snapshot");
         end else begin
            e_pop = exp_q.pop_front();
            chk("snapshot", 80'(got_f), 80'(e_pop.f));
            chk("act_fin", 80'({crono_activo, fin_crono}), 80'({e_pop.act, e_pop.fin}));
         end
      end else if (reset && cur != prev) begin
         bad_change++;
      end
      if (fin_crono && !listo) bad_change++;
      prev = cur;
   end

   // auto-mode monitors: cycle stamps of listo pulses since reset_a release
   int cyc_a = 0;
   int n10 = 0, n40 = 0, last10 = 0, last40 = 0;
   always @(posedge clk) begin
      if (!reset_a) cyc_a <= 0;
      else          cyc_a <= cyc_a + 1;
   end
   always @(negedge clk) begin
      if (listo_a10 && n10 < 4) begin
         n10++;
         if (n10 == 1) chk("a10_first", 80'(cyc_a), 80'(24));
         else          chk("a10_period", 80'(cyc_a - last10), 80'(20));
         last10 = cyc_a;
      end
      if (listo_a40 && n40 < 4) begin
         n40++;
         if (n40 == 1) chk("a40_first", 80'(cyc_a), 80'(54));
         else          chk("a40_period", 80'(cyc_a - last40), 80'(40));
         last40 = cyc_a;
      end
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 40; i++) begin
         if (!ocupado) break;
         @(negedge clk);
      end
      if (i == 40) begin
         n_total++;
         $display("FAIL wait_idle: got ocupado=1 after 40 cycles required 0");
      end
      @(negedge clk);
   endtask

   task automatic sweep(input exp_t e);
      exp_q.push_back(e);
      pulse_start();
      wait_idle();
   endtask

   initial begin
      reset = 1'b0; reset_a = 1'b0; start = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'd0;
      mem[0] = 8'd30; mem[1] = 8'd45; mem[2] = 8'd12; mem[3] = 8'd15; mem[4] = 8'd9; mem[5] = 8'd16;
      mem[6] = 8'h66; mem[10] = 8'hAA;
      repeat (3) @(negedge clk);
      chk("rst_add2", 80'(add2), 80'(0));
      chk("rst_seg", 80'(seg), 80'(0));
      chk("rst_flags", 80'({crono_activo, fin_crono, listo, ocupado}), 80'(0));
      reset = 1'b1; reset_a = 1'b1;
      repeat (2) @(negedge clk);

      // S1: address trace and listo timing
      exp_q.push_back(mk(30, 45, 12, 15, 9, 16, 0, 0, 0, 1'b0, 1'b0));
      pulse_start();
      chk("ocupado_e0", 80'(ocupado), 80'(1));
      for (int k = 0; k < 12; k++) begin
         chk("add2_step", 80'(add2), 80'(k));
         @(negedge clk);
      end
      chk("add2_hold", 80'(add2), 80'(11));
      @(negedge clk);
      chk("e13_listo_ocup", 80'({listo, ocupado}), 80'(2'b01));
      @(negedge clk);
      chk("e14_listo_ocup", 80'({listo, ocupado}), 80'(2'b10));
      repeat (2) @(negedge clk);

      // S2: chronometer running
      mem[7] = 8'd1; mem[8] = 8'd2; mem[9] = 8'd3; mem[11] = 8'hFF;
      sweep(mk(30, 45, 12, 15, 9, 16, 1, 2, 3, 1'b1, 1'b0));
      // S3: chronometer expiry, memory reads 23/59/59
      mem[7] = 8'd23; mem[8] = 8'd59; mem[9] = 8'd59; mem[11] = 8'h00;
      sweep(mk(30, 45, 12, 15, 9, 16, 23, 59, 59, 1'b0, 1'b1));
      // S4/S5: strict decode, 8'h01 counts as stopped
      mem[7] = 8'd0; mem[8] = 8'd0; mem[9] = 8'd5; mem[11] = 8'hFF;
      sweep(mk(30, 45, 12, 15, 9, 16, 0, 0, 5, 1'b1, 1'b0));
      mem[11] = 8'h01;
      sweep(mk(30, 45, 12, 15, 9, 16, 0, 0, 5, 1'b0, 1'b1));

      // S6: coherence with mid-sweep memory change and dropped starts
      mem[0] = 8'd10;
      exp_q.push_back(mk(10, 45, 12, 15, 9, 16, 0, 0, 5, 1'b0, 1'b0));
      pulse_start();
      repeat (2) @(negedge clk);
      mem[0] = 8'd11;
      repeat (3) begin
         @(negedge clk) start = 1'b1;
         @(negedge clk) start = 1'b0;
      end
      wait_idle();
      repeat (20) @(negedge clk);
      sweep(mk(11, 45, 12, 15, 9, 16, 0, 0, 5, 1'b0, 1'b0));

      // reset mid-sweep
      mem[11] = 8'hFF;
      pulse_start();
      repeat (6) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_snap", 80'({seg, min, crono_seg}), 80'(0));
      chk("midrst_flags", 80'({crono_activo, fin_crono, listo, ocupado}), 80'(0));
      chk("midrst_add2", 80'(add2), 80'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (25) @(negedge clk);
      sweep(mk(11, 45, 12, 15, 9, 16, 0, 0, 5, 1'b1, 1'b0));

      for (int i = 0; i < 400 && n40 < 4; i++) @(negedge clk);
      chk("auto_done", 80'({n10 >= 4, n40 >= 4}), 80'(2'b11));
      chk("queue_empty", 80'(exp_q.size()), 80'(0));
      chk("stable_outputs", 80'(bad_change), 80'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
